stb_req_sched: RTL and testbench

Round-robin scheduler that shares one strobe generator among `N_REQ` requesters. It sits between the measurement-unit clients (calibration sequencer, host register port, and similar) and the strobe generator's `stb_req_i`/`stb_valid_o`/`rdy_o` handshake. It grants one requester at a time and issues a clean rising edge on the strobe request. It then tracks the generator's valid handshake through strobe completion, holds the grant for a programmable window, and reports completion or timeout per requester.

---
 rtl/stb_req_sched.sv | 189 ++++++++++++++++++
 tb/tb_stb_req_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stb_req_sched.sv
// Round-robin scheduler sharing one strobe generator among N_REQ requesters.
// Grants one requester, drives a clean strobe-request edge, tracks completion/timeout, holds, then releases.
module stb_req_sched #(
  parameter int N_REQ          = 4,
  parameter int HOLD_W         = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 16
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [N_REQ-1:0]  req_i,
  input  logic [HOLD_W-1:0] hold_cycles_i,
  output logic [N_REQ-1:0]  gnt_o,
  output logic [N_REQ-1:0]  done_o,
  output logic [N_REQ-1:0]  err_o,
  input  logic              stb_rdy_i,
  input  logic              stb_valid_i,
  output logic              stb_req_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  stb_cnt_o
);

  localparam int IDX_W = $clog2(N_REQ);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_ACK  = 3'd1;
  localparam logic [2:0] S_WAIT_DONE = 3'd2;
  localparam logic [2:0] S_HOLD      = 3'd3;
  localparam logic [2:0] S_RELEASE   = 3'd4;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [31:0]       tmo_q, tmo_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [N_REQ-1:0]  err_q, err_d;
  logic              stb_req_q, stb_req_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [N_REQ-1:0]  win_oh;
  logic [N_REQ-1:0]  idx_oh;
  logic              tmo_hit;

  // Search starts one past the last released requester, so each requester gets a turn.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand     = (int'(last_q) + k) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && req_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign win_oh  = N_REQ'(1) << win_idx;
  assign idx_oh  = N_REQ'(1) << idx_q;
  // Compared with >= so a count that passed the limit on an exit edge can never slip past it.
  assign tmo_hit = (tmo_q >= TMO_LAST);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    hold_d    = hold_q;
    tmo_d     = tmo_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = '0;
    stb_req_d = stb_req_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (stb_rdy_i && win_found) begin
          state_d   = S_WAIT_ACK;
          idx_d     = win_idx;
          gnt_d     = win_oh;
          stb_req_d = 1'b1;
          hold_d    = hold_cycles_i;
          tmo_d     = '0;
        end
      end
      S_WAIT_ACK: begin
        tmo_d = tmo_q + 32'd1;
        if (!stb_valid_i) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_hit) begin
          state_d   = S_RELEASE;
          gnt_d     = '0;
          done_d    = idx_oh;
          err_d     = idx_oh;
          stb_req_d = 1'b0;
        end
      end
      S_WAIT_DONE: begin
        tmo_d = tmo_q + 32'd1;
        if (stb_valid_i) begin
          cnt_d     = cnt_q + 1'b1;
          stb_req_d = 1'b0;
          if (hold_q == '0) begin
            state_d = S_RELEASE;
            gnt_d   = '0;
            done_d  = idx_oh;
          end else begin
            state_d = S_HOLD;
          end
        end else if (tmo_hit) begin
          state_d   = S_RELEASE;
          gnt_d     = '0;
          done_d    = idx_oh;
          err_d     = idx_oh;
          stb_req_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_W'(1)) begin
          state_d = S_RELEASE;
          gnt_d   = '0;
          done_d  = idx_oh;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        last_d  = idx_q;
      end
      default: begin
        state_d   = S_IDLE;
        gnt_d     = '0;
        stb_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      last_q    <= IDX_W'(N_REQ - 1);
      hold_q    <= '0;
      tmo_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      stb_req_q <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      tmo_q     <= tmo_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      stb_req_q <= stb_req_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign stb_req_o = stb_req_q;
  assign busy_o    = busy_q;
  assign stb_cnt_o = cnt_q;

endmodule

// File: tb/tb_stb_req_sched.sv
// Bench for stb_req_sched: vector table, directed corner sequences, and randomized traffic
// checked every cycle against a transaction-timeline reference model.
module tb_stb_req_sched;

  localparam int N   = 4;
  localparam int HW  = 16;
  localparam int TMO = 100;
  localparam int CW  = 4;

  logic          clk_i;
  logic          arst_i;
  logic [N-1:0]  req_i;
  logic [HW-1:0] hold_cycles_i;
  logic [N-1:0]  gnt_o, done_o, err_o;
  logic          stb_rdy_i, stb_valid_i;
  logic          stb_req_o, busy_o;
  logic [CW-1:0] stb_cnt_o;

  stb_req_sched #(
    .N_REQ(N), .HOLD_W(HW), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
  ) dut (
    .clk_i(clk_i), .arst_i(arst_i), .req_i(req_i), .hold_cycles_i(hold_cycles_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .stb_rdy_i(stb_rdy_i),
    .stb_valid_i(stb_valid_i), .stb_req_o(stb_req_o), .busy_o(busy_o), .stb_cnt_o(stb_cnt_o)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] v;
    v = 1;
    return v << i;
  endfunction

  function automatic int rr_pick(int ptr, logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      if (((req >> ((ptr + k) % N)) & 1) != 0) return (ptr + k) % N;
    end
    return -1;
  endfunction

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
    end
  end

  // Strobe generator model: accepts a rising request by dropping valid, raises it on completion.
  int gen_drop     = 2;
  int gen_rise     = 10;
  bit gen_hang     = 1'b0;
  bit gen_idle_req = 1'b0;
  int rise_edge    = 0;

  initial begin
    int g_phase;
    int g_cnt;
    bit g_prev_req;
    g_phase     = 0;
    g_cnt       = 0;
    g_prev_req  = 1'b0;
    stb_valid_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (gen_idle_req) begin
        stb_valid_i  = 1'b1;
        g_phase      = 0;
        gen_idle_req = 1'b0;
      end else begin
        case (g_phase)
          0: if (stb_req_o && !g_prev_req) begin g_cnt = gen_drop; g_phase = 1; end
          1: if (g_cnt <= 1) begin
               stb_valid_i = 1'b0;
               g_cnt       = gen_rise;
               g_phase     = gen_hang ? 3 : 2;
             end else g_cnt--;
          2: if (g_cnt <= 1) begin
               stb_valid_i = 1'b1;
               g_phase     = 0;
               rise_edge   = cyc + 1;
             end else g_cnt--;
          default: ;
        endcase
      end
      g_prev_req = stb_req_o;
    end
  end

  // Reference model: tracks each operation as a timeline of edge numbers
  // (grant, acceptance, completion, release) and derives the expected outputs from it.
  initial begin
    bit           m_busy, m_ack, m_err;
    int           m_ptr, m_idx, m_g, m_rel, m_cnt, e;
    int           m_hold;
    logic [N-1:0] x_gnt, x_done, x_err;
    m_busy = 0; m_ack = 0; m_err = 0;
    m_ptr = N - 1; m_idx = 0; m_g = 0; m_rel = -1; m_cnt = 0; m_hold = 0; e = 0;
    forever begin
      @(posedge clk_i);
      #1;
      e = cyc;
      if (!arst_i) begin
        m_busy = 0; m_ptr = N - 1; m_cnt = 0; m_rel = -1; m_err = 0;
      end else if (m_busy && m_rel >= 0 && e == m_rel + 1) begin
        m_busy = 0;
      end else if (!m_busy) begin
        if (stb_rdy_i && req_i != 0) begin
          m_idx  = rr_pick(m_ptr, req_i);
          m_busy = 1; m_g = e; m_hold = int'(hold_cycles_i);
          m_ack  = 0; m_rel = -1; m_err = 0;
        end
      end else if (m_rel < 0) begin
        if (!m_ack) begin
          if (!stb_valid_i) m_ack = 1;
          else if (e - m_g >= TMO) begin m_rel = e; m_err = 1; m_ptr = m_idx; end
        end else begin
          if (stb_valid_i) begin m_cnt++; m_rel = e + m_hold; m_ptr = m_idx; end
          else if (e - m_g >= TMO) begin m_rel = e; m_err = 1; m_ptr = m_idx; end
        end
      end
      x_gnt  = (m_busy && (m_rel < 0 || e < m_rel)) ? onehot(m_idx) : '0;
      x_done = (m_busy && e == m_rel) ? onehot(m_idx) : '0;
      x_err  = m_err ? x_done : '0;
      check("cycle_outputs",
            {gnt_o, done_o, err_o, stb_req_o, busy_o, stb_cnt_o},
            {x_gnt, x_done, x_err, (m_busy && m_rel < 0), m_busy, CW'(m_cnt)});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_gnt(output int e);
    bit ok;
    ok = 0; e = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk_i);
      if (gnt_o != 0) begin ok = 1; e = cyc; end
    end
    check("wait_gnt", ok, 1);
  endtask

  task automatic wait_done(output int e);
    bit ok;
    ok = 0; e = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk_i);
      if (done_o != 0) begin ok = 1; e = cyc; end
    end
    check("wait_done", ok, 1);
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  typedef struct {
    logic [N-1:0] req;
    int           hold;
    int           drop;
    int           rise;
    int           idx;
  } vec_t;

  vec_t tbl [8];
  int   exp_cnt = 0;

  initial begin
    int eg, ed, c0, prev_ed;
    bit seen_gnt, seen_busy, ok;

    tbl[0] = '{4'b0010, 3, 2, 10, 1};
    tbl[1] = '{4'b1111, 0, 1, 4,  2};
    tbl[2] = '{4'b1001, 1, 3, 2,  3};
    tbl[3] = '{4'b1001, 2, 1, 1,  0};
    tbl[4] = '{4'b0100, 5, 2, 7,  2};
    tbl[5] = '{4'b0011, 0, 4, 3,  0};
    tbl[6] = '{4'b0011, 4, 1, 5,  1};
    tbl[7] = '{4'b1000, 1, 2, 2,  3};

    arst_i = 1'b1; req_i = '0; hold_cycles_i = '0; stb_rdy_i = 1'b1;
    #1 arst_i = 1'b0;
    idle_cycles(3);
    check("reset_outputs", {gnt_o, done_o, err_o, stb_req_o, busy_o, stb_cnt_o}, '0);
    arst_i = 1'b1;
    idle_cycles(2);

    for (int i = 0; i < 8; i++) begin
      gen_drop = tbl[i].drop; gen_rise = tbl[i].rise; gen_hang = 1'b0;
      hold_cycles_i = HW'(tbl[i].hold);
      req_i = tbl[i].req;
      c0 = cyc;
      wait_gnt(eg);
      check("tbl_gnt", gnt_o, onehot(tbl[i].idx));
      check("tbl_gnt_lat", eg - c0, 1);
      check("tbl_req_busy", {stb_req_o, busy_o}, 2'b11);
      wait_done(ed);
      exp_cnt++;
      check("tbl_done", done_o, onehot(tbl[i].idx));
      check("tbl_err", err_o, 0);
      check("tbl_done_lat", ed - rise_edge, tbl[i].hold);
      check("tbl_cnt", stb_cnt_o, exp_cnt % (1 << CW));
      req_i = '0;
      idle_cycles(2);
    end

    gen_drop = 1; gen_rise = 3; hold_cycles_i = 1;
    req_i = 4'b1111;
    prev_ed = 0;
    for (int i = 0; i < 8; i++) begin
      wait_gnt(eg);
      check("rr_order", gnt_o, onehot(i % N));
      if (i > 0) check("rr_gap", (eg - prev_ed) >= 2, 1);
      wait_done(ed);
      exp_cnt++;
      check("rr_done", done_o, onehot(i % N));
      check("rr_cnt", stb_cnt_o, exp_cnt % (1 << CW));
      prev_ed = ed;
    end
    req_i = '0;
    check("cnt_wrap", stb_cnt_o, 0);
    idle_cycles(2);

    stb_rdy_i = 1'b0;
    req_i = 4'b0001;
    seen_gnt = 0; seen_busy = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      seen_gnt  = seen_gnt | (gnt_o != 0);
      seen_busy = seen_busy | busy_o;
    end
    check("nr_no_gnt", seen_gnt, 0);
    check("nr_no_busy", seen_busy, 0);
    stb_rdy_i = 1'b1;
    c0 = cyc;
    wait_gnt(eg);
    check("nr_gnt", gnt_o, 4'b0001);
    check("nr_gnt_lat", eg - c0, 1);
    wait_done(ed);
    exp_cnt++;
    req_i = '0;
    idle_cycles(2);

    gen_hang = 1'b1; gen_drop = 2; hold_cycles_i = 2;
    req_i = 4'b0011;
    wait_gnt(eg);
    check("tmo_gnt", gnt_o, 4'b0010);
    wait_done(ed);
    check("tmo_lat", ed - eg, TMO);
    check("tmo_done_err", {done_o, err_o}, {4'b0010, 4'b0010});
    check("tmo_cnt", stb_cnt_o, exp_cnt % (1 << CW));
    gen_hang = 1'b0; gen_idle_req = 1'b1;
    wait_gnt(eg);
    check("tmo_next_gnt", gnt_o, 4'b0001);
    wait_done(ed);
    exp_cnt++;
    check("tmo_next_ok", {done_o, err_o}, {4'b0001, 4'b0000});
    check("tmo_next_cnt", stb_cnt_o, exp_cnt % (1 << CW));
    req_i = '0;
    idle_cycles(2);

    gen_drop = 2; gen_rise = 6; hold_cycles_i = 0;
    req_i = 4'b0100;
    wait_gnt(eg);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_i);
      ok = !stb_valid_i;
    end
    check("wd_accept", ok, 1);
    @(negedge clk_i);
    req_i = '0;
    wait_done(ed);
    exp_cnt++;
    check("wd_done", done_o, 4'b0100);
    check("wd_lat", ed - rise_edge, 0);
    check("wd_cnt", stb_cnt_o, exp_cnt % (1 << CW));
    idle_cycles(2);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_i);
      req_i         = N'($urandom);
      stb_rdy_i     = ($urandom_range(0, 4) != 0);
      hold_cycles_i = HW'($urandom_range(0, 4));
      if (done_o != 0) begin
        int r;
        r = int'($urandom_range(0, 9));
        gen_idle_req = 1'b1;
        gen_hang = (r == 0);
        gen_drop = (r == 1) ? 1000 : int'($urandom_range(1, 4));
        gen_rise = int'($urandom_range(1, 8));
      end
    end
    req_i = '0; stb_rdy_i = 1'b1;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk_i);
      ok = !busy_o;
    end
    check("rand_drain", ok, 1);
    gen_hang = 1'b0; gen_drop = 1; gen_rise = 2; gen_idle_req = 1'b1;
    idle_cycles(2);

    hold_cycles_i = 10;
    req_i = 4'b1111;
    wait_gnt(eg);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_i);
      ok = (gnt_o != 0) && !stb_req_o;
    end
    check("rst_in_hold", ok, 1);
    #2 arst_i = 1'b0;
    #1 check("rst_async", {gnt_o, done_o, err_o, stb_req_o, busy_o, stb_cnt_o}, '0);
    gen_idle_req = 1'b1;
    idle_cycles(2);
    arst_i = 1'b1;
    wait_gnt(eg);
    check("rst_first_gnt", gnt_o, 4'b0001);
    req_i = '0;
    wait_done(ed);
    idle_cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
